cgra_config_sequencer: RTL and testbench



---
 rtl/cgra_config_sequencer_pkg.sv | 23 ++
 rtl/cgra_config_sequencer_if.sv | 32 +++
 rtl/cgra_config_sequencer_counter.sv | 30 +++
 rtl/cgra_config_sequencer.sv | 110 +++++++++++
 tb/tb_cgra_config_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/cgra_config_sequencer_pkg.sv
// Shared types and constants for the CGRA configuration sequencer.
package cgra_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_D = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } seq_state_t;

  localparam int unsigned CFG_BUS_W    = 32;
  localparam logic [31:0] CFG_SENTINEL = 32'hFFFF_FFFF;
  localparam logic [31:0] CFG_NOP_ADDR = 32'h0000_0000;

  // States in which a new start is accepted and busy is low.
  function automatic logic is_quiescent(input seq_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/cgra_config_sequencer_if.sv
// Control, ROM and CGRA-facing bus of the configuration sequencer.
interface cgra_config_sequencer_if
  import cgra_cfg_pkg::*;
#(
  parameter int ROM_AW = 10,
  parameter int RUN_W  = 16
);
  logic                 start_in;
  logic [RUN_W-1:0]     run_cycles_in;
  logic                 rom_en_out;
  logic [ROM_AW-1:0]    rom_addr_out;
  logic [CFG_BUS_W-1:0] rom_data_in;
  logic [CFG_BUS_W-1:0] config_addr_out;
  logic [CFG_BUS_W-1:0] config_data_out;
  logic                 config_valid_out;
  logic                 cgra_run_out;
  logic                 busy_out;
  logic                 done_out;
  logic                 error_out;

  modport master (
    input  start_in, run_cycles_in, rom_data_in,
    output rom_en_out, rom_addr_out, config_addr_out, config_data_out,
           config_valid_out, cgra_run_out, busy_out, done_out, error_out
  );

  modport slave (
    output start_in, run_cycles_in, rom_data_in,
    input  rom_en_out, rom_addr_out, config_addr_out, config_data_out,
           config_valid_out, cgra_run_out, busy_out, done_out, error_out
  );
endinterface

// File: rtl/cgra_config_sequencer_counter.sv
// Loadable saturating down-counter timing the datapath run phase.
module cfg_run_counter #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] count_r;

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});
endmodule

// File: rtl/cgra_config_sequencer.sv
// Walks a ROM of (address, data) pairs onto the CGRA config bus, then runs the datapath.
module cgra_config_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int          ROM_AW   = 10,
  parameter int          RUN_W    = 16,
  parameter logic [31:0] SENTINEL = CFG_SENTINEL
) (
  input logic                      clk_in,
  input logic                      reset_in,
  cgra_config_sequencer_if.master  bus
);
  seq_state_t           state_r;
  logic [ROM_AW-1:0]    ptr_r;
  logic [ROM_AW-1:0]    ptr_next_s;
  logic [CFG_BUS_W-1:0] addr_r;
  logic [CFG_BUS_W-1:0] data_r;
  logic                 valid_r;
  logic                 start_ok_s;
  logic [RUN_W-1:0]     cnt_value_s;
  logic                 cnt_zero_s;

  assign start_ok_s = is_quiescent(state_r) && bus.start_in;
  assign ptr_next_s = ptr_r + ROM_AW'(2);

  cfg_run_counter #(.W(RUN_W)) u_run_counter (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .load       (start_ok_s),
    .load_value (bus.run_cycles_in),
    .dec        (state_r == ST_RUN),
    .count      (cnt_value_s),
    .zero       (cnt_zero_s)
  );

  // Sequencer FSM with pointer and config-pair capture registers.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_r <= ST_IDLE;
      ptr_r   <= {ROM_AW{1'b0}};
      addr_r  <= {CFG_BUS_W{1'b0}};
      data_r  <= {CFG_BUS_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.start_in) begin
            state_r <= ST_FETCH_A;
            ptr_r   <= {ROM_AW{1'b0}};
          end else begin
            state_r <= state_r;
          end
        end
        ST_FETCH_A: state_r <= ST_FETCH_D;
        ST_FETCH_D: begin
          addr_r <= bus.rom_data_in;
          if (bus.rom_data_in == SENTINEL) begin
            state_r <= cnt_zero_s ? ST_DONE : ST_RUN;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          data_r  <= bus.rom_data_in;
          valid_r <= 1'b1;
          ptr_r   <= ptr_next_s;
          // Pointer wrap means the ROM ran out without a sentinel.
          state_r <= (ptr_next_s == {ROM_AW{1'b0}}) ? ST_ERROR : ST_FETCH_A;
        end
        ST_RUN: begin
          if (cnt_value_s <= RUN_W'(1)) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // ROM port decoded from the fetch states.
  always_comb begin
    bus.rom_en_out   = 1'b0;
    bus.rom_addr_out = {ROM_AW{1'b0}};
    case (state_r)
      ST_FETCH_A: begin
        bus.rom_en_out   = 1'b1;
        bus.rom_addr_out = ptr_r;
      end
      ST_FETCH_D: begin
        bus.rom_en_out   = 1'b1;
        bus.rom_addr_out = ptr_r + ROM_AW'(1);
      end
      default: begin
        bus.rom_en_out   = 1'b0;
        bus.rom_addr_out = {ROM_AW{1'b0}};
      end
    endcase
  end

  assign bus.config_valid_out = valid_r;
  assign bus.config_addr_out  = valid_r ? addr_r : CFG_NOP_ADDR;
  assign bus.config_data_out  = valid_r ? data_r : {CFG_BUS_W{1'b0}};
  assign bus.cgra_run_out     = (state_r == ST_RUN);
  assign bus.busy_out         = !is_quiescent(state_r);
  assign bus.done_out         = (state_r == ST_DONE);
  assign bus.error_out        = (state_r == ST_ERROR);
endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Randomized bench for cgra_config_sequencer against a pair-walk reference model.
module tb_cgra_config_sequencer;
  import cgra_cfg_pkg::*;

  localparam int AW     = 4;
  localparam int RW     = 8;
  localparam int DEPTH  = 16;
  localparam int PAIRS  = DEPTH / 2;
  localparam int BUDGET = 400;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } pulse_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cgra_config_sequencer_if #(.ROM_AW(AW), .RUN_W(RW)) bus();

  cgra_config_sequencer #(.ROM_AW(AW), .RUN_W(RW)) dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  logic [31:0] rom [DEPTH];
  logic [31:0] rom_q = 32'h0;
  always @(posedge clk) if (bus.rom_en_out) rom_q <= rom[bus.rom_addr_out];
  assign bus.rom_data_in = rom_q;

  int n_cmp = 0;
  int n_mis = 0;
  pulse_t exp_q[$];
  pulse_t obs_q[$];
  int exp_run_first, exp_done, exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk the ROM pair by pair: pair i pulses at cycle 3i+4, sentinel at i enters RUN at 3i+3.
  task automatic model(input int run);
    exp_q.delete();
    exp_run_first = -1;
    exp_done      = -1;
    exp_err       = -1;
    for (int i = 0; i < PAIRS; i++) begin
      if (rom[2*i] == CFG_SENTINEL) begin
        if (run == 0) exp_done = 3*i + 3;
        else begin
          exp_run_first = 3*i + 3;
          exp_done      = 3*i + 3 + run;
        end
        return;
      end
      exp_q.push_back('{3*i + 4, rom[2*i], rom[2*i+1]});
      if (2*i + 2 == DEPTH) exp_err = 3*i + 4;
    end
  endtask

  function automatic logic [8:0] out_flags();
    return {bus.rom_en_out, |bus.rom_addr_out, |bus.config_addr_out, |bus.config_data_out,
            bus.config_valid_out, bus.cgra_run_out, bus.busy_out, bus.done_out, bus.error_out};
  endfunction

  task automatic start_txn(input int run);
    @(negedge clk);
    bus.start_in      = 1'b1;
    bus.run_cycles_in = 8'(run);
    @(posedge clk);
    #1;
    bus.start_in      = 1'b0;
    bus.run_cycles_in = 8'($urandom);
  endtask

  task automatic do_txn(input string name, input int run, input bit poke);
    int run_first, run_last, run_cnt, done_cyc, err_cyc, leak, bad_busy;
    model(run);
    obs_q.delete();
    run_first = -1; run_last = -1; run_cnt = 0;
    done_cyc = -1; err_cyc = -1; leak = 0; bad_busy = 0;
    start_txn(run);
    for (int k = 1; k <= BUDGET && done_cyc < 0 && err_cyc < 0; k++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      if (bus.config_valid_out)
        obs_q.push_back('{k, bus.config_addr_out, bus.config_data_out});
      else if (bus.config_addr_out != 32'h0 || bus.config_data_out != 32'h0)
        leak++;
      if (bus.cgra_run_out) begin
        if (run_first < 0) run_first = k;
        run_last = k;
        run_cnt++;
        if (poke && run_cnt == 2) bus.start_in = 1'b1;
      end
      if (bus.done_out)  done_cyc = k;
      if (bus.error_out) err_cyc  = k;
      if (bus.busy_out !== !(bus.done_out || bus.error_out)) bad_busy++;
    end
    bus.start_in = 1'b0;
    check_eq($sformatf("%s terminated", name), 32'(done_cyc >= 0 || err_cyc >= 0), 32'd1);
    check_eq($sformatf("%s pulse count", name), 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq($sformatf("%s pulse%0d cycle", name, i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      check_eq($sformatf("%s pulse%0d addr", name, i), obs_q[i].a, exp_q[i].a);
      check_eq($sformatf("%s pulse%0d data", name, i), obs_q[i].d, exp_q[i].d);
    end
    check_eq($sformatf("%s idle bus", name), 32'(leak), 32'd0);
    check_eq($sformatf("%s run start", name), 32'(run_first), 32'(exp_run_first));
    check_eq($sformatf("%s run length", name), 32'(run_cnt), 32'(exp_run_first < 0 ? 0 : run));
    if (run_cnt > 0)
      check_eq($sformatf("%s run contiguous", name), 32'(run_last - run_first + 1), 32'(run_cnt));
    check_eq($sformatf("%s done cycle", name), 32'(done_cyc), 32'(exp_done));
    check_eq($sformatf("%s error cycle", name), 32'(err_cyc), 32'(exp_err));
    check_eq($sformatf("%s busy", name), 32'(bad_busy), 32'd0);
  endtask

  task automatic reset_mid(input string name, input int stop_cyc, input int run);
    start_txn(run);
    repeat (stop_cyc) @(negedge clk);
    check_eq($sformatf("%s active before reset", name), 32'(bus.busy_out), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq($sformatf("%s outputs in reset", name), 32'(out_flags()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq($sformatf("%s idle after release", name), 32'(out_flags()), 32'd0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h0;
    rom[0] = 32'h1; rom[1] = 32'hA; rom[2] = 32'h2; rom[3] = 32'hB; rom[4] = CFG_SENTINEL;
  endtask

  initial begin
    int npairs, run;
    bus.start_in      = 1'b0;
    bus.run_cycles_in = 8'h0;
    load_basic();
    repeat (3) @(negedge clk);
    check_eq("reset outputs", 32'(out_flags()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle outputs", 32'(out_flags()), 32'd0);

    do_txn("basic", 5, 1'b0);
    do_txn("start in run", 10, 1'b1);
    do_txn("rerun from done", 5, 1'b0);

    rom[0] = CFG_SENTINEL;
    do_txn("empty run0", 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom & 32'h7FFF_FFFF;
    do_txn("no sentinel", 7, 1'b0);

    load_basic();
    reset_mid("rst issue", 3, 5);
    reset_mid("rst pulse", 4, 5);
    reset_mid("rst run", 11, 5);
    do_txn("after reset", 4, 1'b0);

    for (int t = 0; t < 12; t++) begin
      npairs = $urandom_range(0, PAIRS);
      run    = $urandom_range(0, 12);
      for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
      for (int i = 0; i < npairs; i++) rom[2*i] = $urandom & 32'h7FFF_FFFF;
      if (npairs < PAIRS) rom[2*npairs] = CFG_SENTINEL;
      do_txn($sformatf("rand%0d", t), run, 1'(t % 3 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
